// File: rtl/ac_control_unit_pkg.sv
// Shared types for the accumulator-machine sequencer: widths, opcodes, ALU ops, FSM states.
package ac_control_unit_pkg;

    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned OPW  = DW - AW;
    localparam int unsigned ALUW = 3;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    typedef enum logic [OPW-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_NOT = 4'h7,
        OP_JMP = 4'h8,
        OP_JZ  = 4'h9,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [ALUW-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_NOT  = 3'd4,
        ALU_PASS = 3'd5
    } alu_op_e;

    typedef struct packed {
        logic    mem_rd;
        logic    mem_wr;
        logic    ac_wen;
        logic    ac_sel;
        logic    pc_load;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/ac_control_unit_decode.sv
// Combinational control decode: state + IR opcode + AC zero flag -> strobes and PC load.
module ac_control_unit_decode
    import ac_control_unit_pkg::*;
(
    input  state_e           state_i,
    input  logic [OPW-1:0]   opcode_i,
    input  logic             ac_zero_i,
    output ctrl_t            ctrl_o
);

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ALU_PASS;
        case (state_i)
            ST_FETCH: ctrl_o.mem_rd = 1'b1;
            ST_EXEC: begin
                // Undefined opcodes (A-E) fall through to the default and act as NOP.
                case (opcode_e'(opcode_i))
                    OP_LDA: begin
                        ctrl_o.mem_rd = 1'b1;
                        ctrl_o.ac_sel = 1'b1;
                        ctrl_o.ac_wen = 1'b1;
                    end
                    OP_STA: ctrl_o.mem_wr = 1'b1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl_o.mem_rd = 1'b1;
                        ctrl_o.ac_wen = 1'b1;
                        ctrl_o.alu_op = alu_op_e'(ALUW'(opcode_i - OPW'(3)));
                    end
                    OP_NOT: begin
                        ctrl_o.ac_wen = 1'b1;
                        ctrl_o.alu_op = ALU_NOT;
                    end
                    OP_JMP: ctrl_o.pc_load = 1'b1;
                    OP_JZ:  ctrl_o.pc_load = ac_zero_i;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ac_control_unit.sv
// Fetch/decode/execute sequencer: owns PC, IR and the 3-cycle FSM; drives memory and AC controls.
module ac_control_unit
    import ac_control_unit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [DW-1:0]   mem_data_i,
    input  logic            ac_zero_i,
    output logic [AW-1:0]   mem_addr_o,
    output logic            mem_rd_o,
    output logic            mem_wr_o,
    output logic [ALUW-1:0] alu_op_o,
    output logic            ac_sel_o,
    output logic            ac_wen_o,
    output logic [AW-1:0]   pc_o,
    output logic            halt_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    ctrl_t         ctrl;

    ac_control_unit_decode u_decode (
        .state_i   (state_q),
        .opcode_i  (ir_q[DW-1:AW]),
        .ac_zero_i (ac_zero_i),
        .ctrl_o    (ctrl)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = mem_data_i;
                pc_d    = pc_q + AW'(1);
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = (ir_q[DW-1:AW] == OP_HLT) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (ctrl.pc_load) pc_d = ir_q[AW-1:0];
                state_d = ST_FETCH;
            end
            default: ;
        endcase
    end

    // Strobes are forced low during reset so a reset edge never commits a write.
    assign mem_addr_o = (state_q == ST_EXEC) ? ir_q[AW-1:0] : pc_q;
    assign mem_rd_o   = ctrl.mem_rd & ~rst_i;
    assign mem_wr_o   = ctrl.mem_wr & ~rst_i;
    assign ac_wen_o   = ctrl.ac_wen & ~rst_i;
    assign ac_sel_o   = ctrl.ac_sel;
    assign alu_op_o   = ctrl.alu_op;
    assign pc_o       = pc_q;
    assign halt_o     = (state_q == ST_HALT);

endmodule
